// File: rtl/register_bank_param_if.sv
// Bus bundle for register_bank_param: the read ports, the write port, the
// clear request and the status flags.
//
// Handshake: ready is a level, not a per-transfer strobe. While ready=1 the
// bank honours RegWrite on every rising edge and returns live read data.
// While ready=0 (clear sweep running) reads return 0, clear_req is ignored,
// and any RegWrite is discarded and reported one cycle later on write_dropped.
interface register_bank_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] read_addr_1;
    logic [ADDR_WIDTH-1:0] read_addr_2;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  RegWrite;
    logic                  clear_req;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic                  ready;
    logic                  write_dropped;

    modport master (
        output read_addr_1, read_addr_2, write_addr, write_data, RegWrite, clear_req,
        input  read_data_1, read_data_2, ready, write_dropped
    );

    modport slave (
        input  read_addr_1, read_addr_2, write_addr, write_data, RegWrite, clear_req,
        output read_data_1, read_data_2, ready, write_dropped
    );
endinterface

// File: rtl/register_bank_param.sv
// Parametrised two-read/one-write register bank. The storage array has no
// reset; a sequential sweep writes zero to every entry after reset or on
// clear_req. Options: hard-wired zero register, write-to-read bypass, and
// registered read data (one-cycle latency).
module register_bank_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int REG_READ   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    register_bank_param_if.slave  bus,
    output logic                  debug_state
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clear_cnt;
    logic [ADDR_WIDTH-1:0] clear_cnt_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  is_idle;
    logic                  write_accept;
    logic                  write_drop_next;
    logic                  write_dropped_q;
    logic [DATA_WIDTH-1:0] read_value_1;
    logic [DATA_WIDTH-1:0] read_value_2;

    assign is_idle     = (state == ST_IDLE);
    assign debug_state = state;
    assign bus.ready   = is_idle;

    // A write lands only in IDLE, not on a clear edge, and never into the
    // hard-wired zero entry.
    assign write_accept = is_idle && bus.RegWrite && !bus.clear_req &&
                          !((ZERO_REG != 0) && (bus.write_addr == '0));

    // Writes lost to a sweep (running or starting this edge) are flagged;
    // writes to the zero entry are dropped silently.
    assign write_drop_next = bus.RegWrite && (!is_idle || bus.clear_req);

    // Read value for one port; bypass only forwards writes that will land.
    function automatic logic [DATA_WIDTH-1:0] read_value(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  idle,
        input logic                  accept,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (!idle) begin
            value = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            value = '0;
        end else if ((BYPASS != 0) && accept && (addr == waddr)) begin
            value = wdata;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // State register and sweep counter; reset restarts the sweep.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_CLEAR;
            clear_cnt <= '0;
        end else begin
            state     <= state_next;
            clear_cnt <= clear_cnt_next;
        end
    end

    // Next-state logic: sweep every entry once, then idle until clear_req.
    always_comb begin
        state_next     = state;
        clear_cnt_next = clear_cnt;
        case (state)
            ST_CLEAR: begin
                if (clear_cnt == LAST_ADDR) begin
                    clear_cnt_next = '0;
                    state_next     = ST_IDLE;
                end else begin
                    clear_cnt_next = clear_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.clear_req) begin
                    clear_cnt_next = '0;
                    state_next     = ST_CLEAR;
                end
            end
            default: begin
                state_next     = ST_CLEAR;
                clear_cnt_next = '0;
            end
        endcase
    end

    // Storage array: sweep writes zero, otherwise accepted writes land.
    always_ff @(posedge clock) begin
        if (!is_idle) begin
            mem[clear_cnt] <= '0;
        end else if (write_accept) begin
            mem[bus.write_addr] <= bus.write_data;
        end
    end

    // One-cycle pulse for each discarded write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_dropped_q <= 1'b0;
        end else begin
            write_dropped_q <= write_drop_next;
        end
    end

    assign bus.write_dropped = write_dropped_q;

    // Read value for both ports, before any optional output register.
    always_comb begin
        read_value_1 = read_value(bus.read_addr_1, mem[bus.read_addr_1], is_idle,
                                  write_accept, bus.write_addr, bus.write_data);
        read_value_2 = read_value(bus.read_addr_2, mem[bus.read_addr_2], is_idle,
                                  write_accept, bus.write_addr, bus.write_data);
    end

    if (REG_READ != 0) begin : g_reg_read
        logic [DATA_WIDTH-1:0] read_q_1;
        logic [DATA_WIDTH-1:0] read_q_2;

        // Registered read: capture this cycle's read value at the edge.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                read_q_1 <= '0;
                read_q_2 <= '0;
            end else begin
                read_q_1 <= read_value_1;
                read_q_2 <= read_value_2;
            end
        end

        assign bus.read_data_1 = read_q_1;
        assign bus.read_data_2 = read_q_2;
    end else begin : g_comb_read
        assign bus.read_data_1 = read_value_1;
        assign bus.read_data_2 = read_value_2;
    end
endmodule

// File: tb/tb_register_bank_param.sv
// Bench for register_bank_param. Two instances share one stimulus stream:
// dut_a (zero register, bypass, combinational read) and dut_b (no zero
// register, no bypass, registered read). Stimulus pushes expected values into
// a queue; a monitor on the falling edge pops and compares them.
module tb_register_bank_param;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 1 << AW;

    logic clock;
    logic reset;
    logic state_a;
    logic state_b;

    register_bank_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    register_bank_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    register_bank_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1), .REG_READ(0)
    ) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a), .debug_state(state_a)
    );

    register_bank_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0), .BYPASS(0), .REG_READ(1)
    ) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b), .debug_state(state_b)
    );

    assign bus_b.read_addr_1 = bus_a.read_addr_1;
    assign bus_b.read_addr_2 = bus_a.read_addr_2;
    assign bus_b.write_addr  = bus_a.write_addr;
    assign bus_b.write_data  = bus_a.write_data;
    assign bus_b.RegWrite    = bus_a.RegWrite;
    assign bus_b.clear_req   = bus_a.clear_req;

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t exp_q[$];
    int   checks_done = 0;
    int   fail_count  = 0;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            0: return bus_a.read_data_1;
            1: return bus_a.read_data_2;
            2: return {31'd0, bus_a.ready};
            3: return {31'd0, bus_a.write_dropped};
            4: return bus_b.read_data_1;
            5: return bus_b.read_data_2;
            6: return {31'd0, bus_b.ready};
            7: return {31'd0, bus_b.write_dropped};
            8: return {31'd0, state_a};
            default: return {31'd0, state_b};
        endcase
    endfunction

    task automatic push_exp(input int sel, input logic [31:0] v, input string name);
        chk_t c;
        c.sel  = sel;
        c.exp  = v;
        c.name = name;
        exp_q.push_back(c);
    endtask

    // Monitor: compare every pending expectation against the live outputs.
    always @(negedge clock) begin
        chk_t        c;
        logic [31:0] got;
        while (exp_q.size() > 0) begin
            c   = exp_q.pop_front();
            got = sample(c.sel);
            checks_done++;
            if (got !== c.exp) begin
                fail_count++;
                $display("FAIL %s (sel %0d): got %h, required %h", c.name, c.sel, got, c.exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_a(input logic [31:0] r1, input logic [31:0] r2, input string n);
        push_exp(0, r1, {n, "_a_rd1"});
        push_exp(1, r2, {n, "_a_rd2"});
    endtask

    task automatic exp_b(input logic [31:0] r1, input logic [31:0] r2, input string n);
        push_exp(4, r1, {n, "_b_rd1"});
        push_exp(5, r2, {n, "_b_rd2"});
    endtask

    task automatic exp_wd(input logic wd, input string n);
        push_exp(3, {31'd0, wd}, {n, "_a_wd"});
        push_exp(7, {31'd0, wd}, {n, "_b_wd"});
    endtask

    task automatic exp_status(input logic rdy, input logic wd, input string n);
        push_exp(2, {31'd0, rdy}, {n, "_a_ready"});
        push_exp(6, {31'd0, rdy}, {n, "_b_ready"});
        push_exp(8, {31'd0, rdy}, {n, "_a_state"});
        push_exp(9, {31'd0, rdy}, {n, "_b_state"});
        exp_wd(wd, n);
    endtask

    // Present two read addresses; dut_a answers now, dut_b after the edge.
    task automatic read_check(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [31:0] ea1, input logic [31:0] ea2,
                              input logic [31:0] eb1, input logic [31:0] eb2,
                              input string n);
        bus_a.read_addr_1 = a1;
        bus_a.read_addr_2 = a2;
        bus_a.RegWrite    = 1'b0;
        bus_a.clear_req   = 1'b0;
        exp_a(ea1, ea2, n);
        step();
        exp_b(eb1, eb2, n);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic wd, input string n);
        bus_a.write_addr = addr;
        bus_a.write_data = data;
        bus_a.RegWrite   = 1'b1;
        step();
        bus_a.RegWrite   = 1'b0;
        exp_wd(wd, n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset             = 1'b0;
        bus_a.read_addr_1 = '0;
        bus_a.read_addr_2 = '0;
        bus_a.write_addr  = '0;
        bus_a.write_data  = '0;
        bus_a.RegWrite    = 1'b0;
        bus_a.clear_req   = 1'b0;

        // Reset held for three cycles.
        repeat (3) begin
            step();
            exp_status(1'b0, 1'b0, "in_reset");
            exp_a(32'd0, 32'd0, "in_reset");
            exp_b(32'd0, 32'd0, "in_reset");
        end
        reset = 1'b1;

        // Sweep after reset: ready rises on the 32nd edge.
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            exp_status(i == DEPTH, 1'b0, "reset_sweep");
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_check(AW'(i), AW'(DEPTH - 1 - i), 32'd0, 32'd0, 32'd0, 32'd0, "swept_zero");
        end

        // Basic write/read on both ports.
        do_write(5'd5, 32'hDEADBEEF, 1'b0, "write5");
        read_check(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, "read5");

        // Zero register: dut_a discards silently, dut_b stores.
        do_write(5'd0, 32'h12345678, 1'b0, "write0");
        read_check(5'd0, 5'd0, 32'd0, 32'd0, 32'h12345678, 32'h12345678, "read0");

        // Same-cycle write/read of address 7.
        bus_a.read_addr_1 = 5'd7;
        bus_a.read_addr_2 = 5'd7;
        bus_a.write_addr  = 5'd7;
        bus_a.write_data  = 32'hA5A5A5A5;
        bus_a.RegWrite    = 1'b1;
        exp_a(32'hA5A5A5A5, 32'hA5A5A5A5, "bypass");
        step();
        bus_a.RegWrite    = 1'b0;
        exp_b(32'd0, 32'd0, "no_bypass_old");
        read_check(5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, "read7");

        // Fill 1..31 with their index.
        for (int i = 1; i < DEPTH; i++) begin
            do_write(AW'(i), 32'(i), 1'b0, "fill");
        end
        read_check(5'd3, 5'd30, 32'd3, 32'd30, 32'd3, 32'd30, "fill_rd");
        read_check(5'd31, 5'd1, 32'd31, 32'd1, 32'd31, 32'd1, "fill_rd");

        // Soft clear with a colliding write to address 3.
        bus_a.write_addr = 5'd3;
        bus_a.write_data = 32'h0000FFFF;
        bus_a.RegWrite   = 1'b1;
        bus_a.clear_req  = 1'b1;
        step();
        bus_a.RegWrite   = 1'b0;
        bus_a.clear_req  = 1'b0;
        exp_status(1'b0, 1'b1, "clear_collide");
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            exp_status(i == DEPTH, i == 6, "clear_sweep");
            exp_a(32'd0, 32'd0, "clear_sweep");
            exp_b(32'd0, 32'd0, "clear_sweep");
            if (i == 5) begin
                bus_a.write_addr = 5'd9;
                bus_a.write_data = 32'h55;
                bus_a.RegWrite   = 1'b1;
            end
            if (i == 6) begin
                bus_a.RegWrite = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_check(AW'(i), AW'(DEPTH - 1 - i), 32'd0, 32'd0, 32'd0, 32'd0, "cleared_zero");
        end

        // Reset in the middle of a sweep, at clear_cnt = 10.
        do_write(5'd4, 32'h11, 1'b0, "pre_reset_write");
        bus_a.read_addr_1 = 5'd4;
        bus_a.read_addr_2 = 5'd4;
        bus_a.clear_req   = 1'b1;
        step();
        bus_a.clear_req   = 1'b0;
        repeat (10) step();
        reset = 1'b0;
        exp_status(1'b0, 1'b0, "mid_reset");
        exp_b(32'd0, 32'd0, "mid_reset");
        repeat (2) begin
            step();
            exp_status(1'b0, 1'b0, "mid_reset_hold");
            exp_b(32'd0, 32'd0, "mid_reset_hold");
        end
        reset = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            exp_status(i == DEPTH, 1'b0, "restart_sweep");
            exp_b(32'd0, 32'd0, "restart_sweep");
        end
        read_check(5'd4, 5'd4, 32'd0, 32'd0, 32'd0, 32'd0, "after_restart");

        // Top address after the restart.
        do_write(5'd31, 32'hCAFEF00D, 1'b0, "write31");
        read_check(5'd31, 5'd0, 32'hCAFEF00D, 32'd0, 32'hCAFEF00D, 32'd0, "read31");

        // ---------------- final report ----------------
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            fail_count++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
        $finish;
    end
endmodule
